chip_test_controller: RTL and testbench
=======================================

// Module: chip_test_controller
// PURPOSE
//  Front-panel sequencer that drives the Run/Done/RSLT/DISP_RSLT handshake of the per-chip checkers.
//  - Takes a raw Start button and a chip select, and pulses Run to the selected checker.
//  - Waits for that checker's Done, captures its RSLT and shows pass/fail for a hold time.
//  - Releases the checker by asserting DISP_RSLT.
//  - Keeps saturating pass/fail tallies and a watchdog against a hung checker.
// PARAMETERS
//  NCHK            8     number of checker slots (1..8); Sel values >= NCHK are invalid
//  HOLD_CYCLES     1000  cycles Pass/Fail are shown before release (>=1)
//  TIMEOUT_CYCLES  256   max cycles in WAIT before declaring timeout (>=4)
// PORTS
//  Clk        in   1     clock
//  Reset      in   1     synchronous, active-high reset
//  Start      in   1     raw start button, active-high, asynchronous to Clk
//  Sel        in   3     checker index; latched at launch
//  Done_i     in   NCHK  Done from each checker
//  Rslt_i     in   NCHK  RSLT from each checker (1 = chip good)
//  Run_o      out  NCHK  Run to each checker; one-hot
//  Disp_rslt  out  1     DISP_RSLT, broadcast to all checkers
//  Busy       out  1     high in any state other than IDLE
//  Pass       out  1     high in SHOW when the captured result = 1 and no timeout
//  Fail       out  1     high in SHOW when the captured result = 0 or on timeout
//  Timeout    out  1     sticky until the next launch; set by the watchdog
//  Pass_cnt   out  8     tests passed, saturates at 255
//  Fail_cnt   out  8     tests failed or timed out, saturates at 255
//  state_o    out  3     current state encoding (debug)
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0, both counters 0, synchronizer flops 0.
//    Reset asserted in any state aborts the test; Run_o = 0 on the next edge.
//  - Start input: 2-flop synchronizer, then a rising-edge detector producing start_p (1 cycle).
//  - States: IDLE=0, LAUNCH=1, WAIT=2, CAPTURE=3, SHOW=4, RELEASE=5.
//  - IDLE:
//    - start_p with Sel < NCHK: latch sel_q <= Sel, clear Timeout, go LAUNCH.
//    - start_p with Sel >= NCHK: ignored, stay IDLE.
//  - LAUNCH: Run_o[sel_q] = 1 for exactly this one cycle; go WAIT.
//  - WAIT: watchdog counter wd counts from 0.
//    - Done_i[sel_q] = 1: go CAPTURE.
//    - Otherwise, when wd == TIMEOUT_CYCLES-1: Timeout <= 1, result <= 0, go SHOW.
//  - CAPTURE: the checker asserts Done one cycle before its RSLT is final, so the result is
//    sampled here (second cycle of Done), never in WAIT.
//    - Done_i[sel_q] still 1: result <= Rslt_i[sel_q], go SHOW.
//    - Done_i[sel_q] dropped: treated as a glitch; return to WAIT with wd unchanged.
//  - SHOW:
//    - On entry (first cycle): Pass_cnt or Fail_cnt += 1, saturating.
//    - Pass/Fail held for HOLD_CYCLES cycles, then go RELEASE.
//  - RELEASE: Disp_rslt = 1 while Done_i[sel_q] = 1, up to 4 cycles, then go IDLE.
//    If Done is already low (timeout case), assert Disp_rslt for 1 cycle, then go IDLE.
//  - Input handling outside IDLE:
//    - start_p is ignored.
//    - Sel changes are ignored after launch.
//    - Done/Rslt of non-selected slots are ignored.
//  - Run_o is never asserted outside LAUNCH. Pass and Fail are never both 1.
//  - Latencies:
//    - start_p to Run_o: 1 cycle.
//    - Start pin to Run_o: 4 cycles.
// TESTING
//  - Good-chip model: Sel=0, Start pulse, model sets Done 3 cycles after Run with Rslt=1 on
//    Done's 2nd cycle -> Pass for HOLD_CYCLES, Pass_cnt=1, one Disp_rslt pulse, return to IDLE.
//  - Bad-chip model: Sel=5, Rslt=1 on Done's 1st cycle and 0 on the 2nd -> Fail=1, Fail_cnt=1,
//    Pass_cnt unchanged (proves sampling happens in CAPTURE).
//  - Hung checker: Done never rises -> Timeout=1 and Fail=1 after TIMEOUT_CYCLES cycles in WAIT,
//    Fail_cnt increments, Disp_rslt is a 1-cycle pulse.
//  - Start held high for 100 cycles, plus Start pulses during SHOW -> exactly one Run_o pulse.
//    Sel=7 with NCHK=4 -> no Run_o, Busy stays 0.
//  - Run 256 passing tests -> Pass_cnt saturates at 255.
//    Reset asserted in WAIT -> all outputs 0 next cycle.
//  - Sel changed from 2 to 3 during WAIT, and Done pulsed for 1 cycle only ->
//    still waits on slot 2, returns to WAIT, no capture.

Source files
------------

// File: rtl/chip_test_controller.sv
// Front-panel sequencer for the per-chip checkers: launches Run on the selected slot, captures
// RSLT on the second cycle of Done, shows pass/fail for a hold time, then releases via DISP_RSLT.
module chip_test_controller #(
  parameter int NCHK           = 8,
  parameter int HOLD_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [2:0]      Sel,
  input  logic [NCHK-1:0] Done_i,
  input  logic [NCHK-1:0] Rslt_i,
  output logic [NCHK-1:0] Run_o,
  output logic            Disp_rslt,
  output logic            Busy,
  output logic            Pass,
  output logic            Fail,
  output logic            Timeout,
  output logic [7:0]      Pass_cnt,
  output logic [7:0]      Fail_cnt,
  output logic [2:0]      state_o
);

  localparam int WD_W   = $clog2(TIMEOUT_CYCLES);
  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]        NCHK_4    = 4'(NCHK);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    SHOW    = 3'd4,
    RELEASE = 3'd5
  } state_t;

  state_t              state_reg;
  logic                sync1_reg, sync2_reg, sync3_reg, start_p_reg;
  logic [2:0]          sel_reg;
  logic [WD_W-1:0]     wd_reg;
  logic [HOLD_W-1:0]   hold_reg;
  logic [1:0]          rel_reg;
  logic [7:0]          done_pad, rslt_pad;
  logic                done_sel, rslt_sel, sel_ok;

  // Widen the checker buses to the full 3-bit Sel range so unused slots read as idle.
  for (genvar gi = 0; gi < 8; gi++) begin : g_pad
    if (gi < NCHK) begin : g_used
      assign done_pad[gi] = Done_i[gi];
      assign rslt_pad[gi] = Rslt_i[gi];
    end else begin : g_unused
      assign done_pad[gi] = 1'b0;
      assign rslt_pad[gi] = 1'b0;
    end
  end

  assign done_sel = done_pad[sel_reg];
  assign rslt_sel = rslt_pad[sel_reg];
  assign sel_ok   = ({1'b0, Sel} < NCHK_4);
  assign state_o  = state_reg;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg   <= IDLE;
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      sync3_reg   <= 1'b0;
      start_p_reg <= 1'b0;
      sel_reg     <= '0;
      wd_reg      <= '0;
      hold_reg    <= '0;
      rel_reg     <= '0;
      Run_o       <= '0;
      Disp_rslt   <= 1'b0;
      Busy        <= 1'b0;
      Pass        <= 1'b0;
      Fail        <= 1'b0;
      Timeout     <= 1'b0;
      Pass_cnt    <= '0;
      Fail_cnt    <= '0;
    end else begin
      sync1_reg   <= Start;
      sync2_reg   <= sync1_reg;
      sync3_reg   <= sync2_reg;
      start_p_reg <= sync2_reg & ~sync3_reg;
      Run_o       <= '0;
      case (state_reg)
        IDLE: begin
          if (start_p_reg && sel_ok) begin
            sel_reg   <= Sel;
            Timeout   <= 1'b0;
            Busy      <= 1'b1;
            state_reg <= LAUNCH;
            for (int i = 0; i < NCHK; i++) Run_o[i] <= (Sel == 3'(i));
          end
        end
        LAUNCH: begin
          wd_reg    <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (done_sel) begin
            state_reg <= CAPTURE;
          end else if (wd_reg == WD_LAST) begin
            Timeout   <= 1'b1;
            Fail      <= 1'b1;
            Fail_cnt  <= sat_inc(Fail_cnt);
            hold_reg  <= '0;
            state_reg <= SHOW;
          end else begin
            wd_reg <= wd_reg + 1'b1;
          end
        end
        CAPTURE: begin
          // Done must still be high on its second cycle; a one-cycle Done is a glitch.
          if (done_sel) begin
            if (rslt_sel) begin
              Pass     <= 1'b1;
              Pass_cnt <= sat_inc(Pass_cnt);
            end else begin
              Fail     <= 1'b1;
              Fail_cnt <= sat_inc(Fail_cnt);
            end
            hold_reg  <= '0;
            state_reg <= SHOW;
          end else begin
            state_reg <= WAIT;
          end
        end
        SHOW: begin
          if (hold_reg == HOLD_LAST) begin
            Pass      <= 1'b0;
            Fail      <= 1'b0;
            Disp_rslt <= 1'b1;
            rel_reg   <= '0;
            state_reg <= RELEASE;
          end else begin
            hold_reg <= hold_reg + 1'b1;
          end
        end
        RELEASE: begin
          // Keep DISP_RSLT up while the checker still holds Done, capped at four cycles.
          if (done_sel && rel_reg != 2'd3) begin
            rel_reg <= rel_reg + 1'b1;
          end else begin
            Disp_rslt <= 1'b0;
            Busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          Disp_rslt <= 1'b0;
          Busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chip_test_controller.sv
// Randomised scoreboard bench for chip_test_controller: stimulus pushes expected launches,
// results and release lengths; a negedge monitor pops and compares as the DUT produces them.
module tb_chip_test_controller;

  localparam int NCHK = 8;
  localparam int HOLD = 10;
  localparam int TO   = 32;

  logic            Clk = 1'b0;
  logic            Reset, Start;
  logic [2:0]      Sel;
  logic [NCHK-1:0] Done_i, Rslt_i, Run_o;
  logic            Disp_rslt, Busy, Pass, Fail, Timeout;
  logic [7:0]      Pass_cnt, Fail_cnt;
  logic [2:0]      state_o;

  logic            Reset2, Start2;
  logic [2:0]      Sel2;
  logic [3:0]      Done2, Rslt2, Run2;
  logic            Disp2, Busy2, Pass2, Fail2, Timeout2;
  logic [7:0]      Pcnt2, Fcnt2;
  logic [2:0]      state2;

  chip_test_controller #(.NCHK(NCHK), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Sel(Sel), .Done_i(Done_i), .Rslt_i(Rslt_i),
    .Run_o(Run_o), .Disp_rslt(Disp_rslt), .Busy(Busy), .Pass(Pass), .Fail(Fail),
    .Timeout(Timeout), .Pass_cnt(Pass_cnt), .Fail_cnt(Fail_cnt), .state_o(state_o));

  chip_test_controller #(.NCHK(4), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO)) dut4 (
    .Clk(Clk), .Reset(Reset2), .Start(Start2), .Sel(Sel2), .Done_i(Done2), .Rslt_i(Rslt2),
    .Run_o(Run2), .Disp_rslt(Disp2), .Busy(Busy2), .Pass(Pass2), .Fail(Fail2),
    .Timeout(Timeout2), .Pass_cnt(Pcnt2), .Fail_cnt(Fcnt2), .state_o(state2));

  always #5 Clk = ~Clk;

  int cyc = 0;
  initial forever begin
    @(posedge Clk);
    cyc = cyc + 1;
  end

  typedef struct { logic [7:0] onehot; int start_cyc; } run_exp_t;
  typedef struct { bit pass; bit fail; bit tmo; int pcnt; int fcnt; int lat; } res_exp_t;

  run_exp_t run_q[$];
  res_exp_t res_q[$];
  int       disp_q[$];
  int       m_pass = 0, m_fail = 0;
  int       n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Monitor: compares whatever the DUT presents against the head of each expectation queue.
  initial begin
    run_exp_t re;
    res_exp_t rr;
    int run_cyc = 0, show_len = 0, disp_len = 0, exp_disp;
    bit prev_pf = 0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        show_len = 0; disp_len = 0; prev_pf = 0;
      end else begin
        if (Run_o != '0) begin
          if (run_q.size() == 0) chk("run_unexpected", Run_o, 0);
          else begin
            re = run_q.pop_front();
            chk("run_onehot", Run_o, re.onehot);
            chk("run_latency", cyc - re.start_cyc, 4);
            chk("timeout_clear_at_launch", Timeout, 0);
            chk("busy_at_launch", Busy, 1);
            run_cyc = cyc;
          end
        end
        if (Pass && Fail) chk("pass_fail_exclusive", 1, 0);
        if ((Pass || Fail) && !prev_pf) begin
          if (res_q.size() == 0) chk("result_unexpected", 1, 0);
          else begin
            rr = res_q.pop_front();
            chk("pass", Pass, rr.pass);
            chk("fail", Fail, rr.fail);
            chk("timeout", Timeout, rr.tmo);
            chk("pass_cnt", Pass_cnt, rr.pcnt);
            chk("fail_cnt", Fail_cnt, rr.fcnt);
            chk("result_latency", cyc - run_cyc, rr.lat);
            $display("result: pass=%0d fail=%0d timeout=%0d pass_cnt=%0d fail_cnt=%0d",
                     Pass, Fail, Timeout, Pass_cnt, Fail_cnt);
          end
        end
        if (Pass || Fail) show_len++;
        else if (show_len > 0) begin
          chk("show_length", show_len, HOLD);
          show_len = 0;
        end
        if (Disp_rslt) disp_len++;
        else if (disp_len > 0) begin
          exp_disp = (disp_q.size() > 0) ? disp_q.pop_front() : -1;
          chk("disp_length", disp_len, exp_disp);
          disp_len = 0;
        end
        prev_pf = Pass || Fail;
      end
    end
  end

  // Checker slot model. mode 0: normal Done, 1: hung, 2: one-cycle Done glitch then Sel moved.
  task automatic checker_model(input int sel, input int mode, input bit r1, input bit r2,
                               input int delay, input int hold_after, input bit pokes);
    int n, pc, other;
    n = 0;
    while (!Run_o[sel] && n < 20) begin tick; n++; end
    if (n >= 20) chk("wait_run", 0, 1);
    if (mode != 1) begin
      repeat (delay) tick;
      Done_i[sel] = 1'b1;
      Rslt_i[sel] = r1;
      tick;
      if (mode == 0) Rslt_i[sel] = r2;
      else begin
        other = (sel + 1) % NCHK;
        Done_i[sel]   = 1'b0;
        Sel           = 3'(other);
        Done_i[other] = 1'b1;
        Rslt_i[other] = 1'b1;
        tick;
        chk("glitch_back_to_wait", state_o, 2);
      end
    end
    n = 0; pc = 0;
    while (!Disp_rslt && n < TO + HOLD + 20) begin
      if (pokes && (Pass || Fail) && pc < 5) begin Start = ~Start; pc++; end
      tick; n++;
    end
    if (n >= TO + HOLD + 20) chk("wait_disp", 0, 1);
    if (pokes) Start = 1'b0;
    repeat (hold_after) tick;
    Done_i = '0;
    Rslt_i = '0;
  endtask

  task automatic run_test(input int sel, input int mode, input bit r1, input bit r2,
                          input int delay, input int hold_after, input int start_len,
                          input bit pokes);
    run_exp_t re;
    res_exp_t e;
    int n;
    Start = 1'b0;
    repeat (4) tick;
    Sel = 3'(sel);
    re.onehot = 8'd1 << sel;
    re.start_cyc = cyc;
    if (mode == 0) begin
      e.pass = r2; e.fail = !r2; e.tmo = 0; e.lat = delay + 2;
    end else begin
      e.pass = 0; e.fail = 1; e.tmo = 1; e.lat = 1 + TO + ((mode == 2) ? 2 : 0);
    end
    if (e.pass) m_pass = (m_pass < 255) ? m_pass + 1 : 255;
    else        m_fail = (m_fail < 255) ? m_fail + 1 : 255;
    e.pcnt = m_pass;
    e.fcnt = m_fail;
    run_q.push_back(re);
    res_q.push_back(e);
    disp_q.push_back((mode == 0) ? ((hold_after + 1 < 4) ? hold_after + 1 : 4) : 1);
    Start = 1'b1;
    fork
      begin repeat (start_len) tick; Start = 1'b0; end
      checker_model(sel, mode, r1, r2, delay, hold_after, pokes);
    join
    n = 0;
    while (Busy && n < 50) begin tick; n++; end
    if (n >= 50) chk("wait_idle", 0, 1);
    Start = 1'b0;
  endtask

  initial begin
    int n;
    Reset = 1; Start = 0; Sel = 0; Done_i = '0; Rslt_i = '0;
    Reset2 = 1; Start2 = 0; Sel2 = 0; Done2 = '0; Rslt2 = '0;
    repeat (3) tick;
    chk("reset_run", Run_o, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_pass_fail", {Pass, Fail, Timeout, Disp_rslt}, 0);
    chk("reset_counts", {Pass_cnt, Fail_cnt}, 0);
    chk("reset_state", state_o, 0);
    Reset = 0; Reset2 = 0;
    tick;

    run_test(0, 0, 1'b1, 1'b1, 3, 0, 1, 0);    // good chip
    run_test(5, 0, 1'b1, 1'b0, 3, 0, 1, 0);    // bad chip, RSLT flips on Done's 2nd cycle
    run_test(2, 1, 1'b0, 1'b0, 0, 0, 1, 0);    // hung checker
    run_test(4, 0, 1'b1, 1'b1, 2, 0, 100, 0);  // Start held for 100 cycles
    run_test(6, 0, 1'b0, 1'b1, 1, 0, 1, 1);    // Start poked during SHOW
    run_test(1, 0, 1'b0, 1'b1, 2, 2, 1, 0);    // Done held 2 cycles into release
    run_test(7, 0, 1'b1, 1'b1, 4, 7, 1, 0);    // release capped at 4 cycles
    run_test(2, 2, 1'b0, 1'b0, 3, 0, 1, 0);    // glitch, Sel moved to 3

    // NCHK=4 instance: out-of-range selects are ignored, the last valid slot launches.
    for (int s = 7; s >= 4; s -= 3) begin
      Sel2 = 3'(s);
      Start2 = 1; tick; Start2 = 0;
      repeat (12) begin tick; chk("nchk4_invalid_idle", {Run2, Busy2}, 0); end
    end
    Sel2 = 3'd3;
    Start2 = 1; tick; Start2 = 0;
    n = 0;
    while (Run2 == '0 && n < 10) begin tick; n++; end
    chk("nchk4_valid_run", Run2, 4'b1000);
    Reset2 = 1; tick; Reset2 = 0;

    for (int t = 0; t < 20; t++)
      run_test($urandom_range(0, 7), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(1, 6), $urandom_range(0, 6),
               $urandom_range(1, 3), 1'($urandom_range(0, 1)));

    for (int t = 0; t < 256; t++)
      run_test($urandom_range(0, 7), 0, 1'($urandom_range(0, 1)), 1'b1,
               $urandom_range(1, 4), $urandom_range(0, 2), 1, 0);
    chk("pass_cnt_saturated", Pass_cnt, 255);

    // Reset while waiting on a checker aborts the test.
    repeat (4) tick;
    Sel = 3'd1;
    begin
      run_exp_t re;
      re.onehot = 8'd2;
      re.start_cyc = cyc;
      run_q.push_back(re);
    end
    Start = 1; tick; Start = 0;
    n = 0;
    while (state_o != 3'd2 && n < 20) begin tick; n++; end
    chk("reached_wait", state_o, 2);
    Reset = 1;
    tick;
    chk("abort_run", Run_o, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_flags", {Pass, Fail, Timeout, Disp_rslt}, 0);
    chk("abort_counts", {Pass_cnt, Fail_cnt}, 0);
    chk("abort_state", state_o, 0);
    Reset = 0;
    m_pass = 0; m_fail = 0;
    repeat (3) tick;

    chk("run_q_drained", run_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    chk("disp_q_drained", disp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
